// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle RV32I core: walks the shared datapath through
// fetch/decode/execute/memory/writeback, stalling on mem_ready and trapping on bad opcodes.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       instr_done
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;
  localparam logic [1:0] SRC_B_RD2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t state, next_state;

  // Raw enables before the reset gate.
  logic pc_update, branch, ir_en, mw_en, rw_en, done_en;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BEQ:            next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_ALUWB;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_JALR:     next_state = S_JALRPC;
      S_JALRPC:   next_state = S_ALUWB;
      S_LUI:      next_state = S_ALUWB;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mw_en      = 1'b0;
    rw_en      = 1'b0;
    done_en    = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
        ir_en      = mem_ready;
        pc_update  = mem_ready;
      end
      // OldPC+imm lands in ALUOut here so branch/jal/auipc can use it later.
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        rw_en      = 1'b1;
        done_en    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mw_en   = 1'b1;
        done_en = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        rw_en   = 1'b1;
        done_en = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        done_en   = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      S_JALRPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Architectural side effects are suppressed for the whole reset cycle.
  assign pc_write   = ~reset & (pc_update | (branch & zero));
  assign ir_write   = ~reset & ir_en;
  assign mem_write  = ~reset & mw_en;
  assign reg_write  = ~reset & rw_en;
  assign instr_done = ~reset & done_en;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed cycle table plus a randomized run against an instruction-step model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic illegal, instr_done;
  } outs_t;

  //                                pcw adr ir mw rw  rs     a      b      alu  ill done
  localparam outs_t O_FETCH   = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,2'd0,2'd2,2'd0,1'b0,1'b0};
  localparam outs_t O_FETCH_S = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,2'd0,1'b0,1'b0};
  localparam outs_t O_DEC     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,2'd0,1'b0,1'b0};
  localparam outs_t O_MADR    = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,1'b0};
  localparam outs_t O_MRD     = '{1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam outs_t O_MWB     = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,2'd0,2'd0,1'b0,1'b1};
  localparam outs_t O_MWR     = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1};
  localparam outs_t O_MWR_S   = '{1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam outs_t O_EXR     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd2,1'b0,1'b0};
  localparam outs_t O_EXI     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd2,1'b0,1'b0};
  localparam outs_t O_AWB     = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1};
  localparam outs_t O_BEQ_T   = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd1,1'b0,1'b1};
  localparam outs_t O_BEQ_N   = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,2'd1,1'b0,1'b1};
  localparam outs_t O_JAL     = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0,1'b0};
  localparam outs_t O_JALR    = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,1'b0};
  localparam outs_t O_JPC     = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0,1'b0};
  localparam outs_t O_LUI     = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd1,2'd0,1'b0,1'b0};
  localparam outs_t O_TRAP    = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b1,1'b0};
  // During reset only the enables and instr_done are defined.
  localparam outs_t EN_MASK   = '{1'b1,1'b0,1'b1,1'b1,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b1};

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                         RI = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         BAD = 7'b1111111;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input outs_t exp, input bit en_only);
    outs_t got, m;
    got = '{pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_op, illegal, instr_done};
    m = en_only ? EN_MASK : '1;
    n_tests++;
    if ((got & m) !== (exp & m)) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h (mask %h)", name, $time, got, exp, m);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       z, mr;
    outs_t      exp;
    string      name;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic rst, input logic [6:0] opc, input logic z, input logic mr,
                     input outs_t exp, input string name);
    vec_t v;
    v.rst = rst; v.opc = opc; v.z = z; v.mr = mr; v.exp = exp; v.name = name;
    vt.push_back(v);
  endtask

  // ---------------- randomized model ----------------
  // Each instruction is a list of steps; a waiting step repeats while mem_ready is low.
  typedef struct {
    outs_t o;
    bit    wait_rdy;
    bit    sticky;
    bit    br;
  } step_t;
  step_t      seq[$];
  int         pos;
  logic [6:0] cur_op;

  task automatic push(input outs_t o, input bit w, input bit s, input bit b);
    step_t t;
    t.o = o; t.wait_rdy = w; t.sticky = s; t.br = b;
    seq.push_back(t);
  endtask

  task automatic new_instr();
    logic [6:0] ops [9];
    ops = '{LD, ST, RR, RI, BQ, JL, JR, LU, AU};
    if ($urandom_range(0, 11) == 0) cur_op = 7'($urandom_range(0, 127));
    else                            cur_op = ops[$urandom_range(0, 8)];
    seq.delete();
    pos = 0;
    push(O_FETCH, 1, 0, 0);
    push(O_DEC, 0, 0, 0);
    case (cur_op)
      LD: begin push(O_MADR, 0, 0, 0); push(O_MRD, 1, 0, 0); push(O_MWB, 0, 0, 0); end
      ST: begin push(O_MADR, 0, 0, 0); push(O_MWR, 1, 0, 0); end
      RR: begin push(O_EXR, 0, 0, 0); push(O_AWB, 0, 0, 0); end
      RI: begin push(O_EXI, 0, 0, 0); push(O_AWB, 0, 0, 0); end
      BQ: push(O_BEQ_N, 0, 0, 1);
      JL: begin push(O_JAL, 0, 0, 0); push(O_AWB, 0, 0, 0); end
      JR: begin push(O_JALR, 0, 0, 0); push(O_JPC, 0, 0, 0); push(O_AWB, 0, 0, 0); end
      LU: begin push(O_LUI, 0, 0, 0); push(O_AWB, 0, 0, 0); end
      AU: push(O_AWB, 0, 0, 0);
      default: push(O_TRAP, 0, 1, 0);
    endcase
  endtask

  initial begin
    // reset from whatever state, mem_ready high
    add(1, 0,  0, 1, '0,        "rst0");
    add(1, 0,  0, 1, '0,        "rst1");
    // add: 4 cycles
    add(0, RR, 0, 1, O_FETCH,   "add_fetch");
    add(0, RR, 0, 1, O_DEC,     "add_dec");
    add(0, RR, 0, 1, O_EXR,     "add_exec");
    add(0, RR, 0, 1, O_AWB,     "add_wb");
    // lw with 3 stall cycles in MEMREAD
    add(0, LD, 0, 1, O_FETCH,   "lw_fetch");
    add(0, LD, 0, 0, O_DEC,     "lw_dec");
    add(0, LD, 0, 1, O_MADR,    "lw_madr");
    add(0, LD, 0, 0, O_MRD,     "lw_rd_s0");
    add(0, LD, 0, 0, O_MRD,     "lw_rd_s1");
    add(0, LD, 0, 0, O_MRD,     "lw_rd_s2");
    add(0, LD, 0, 1, O_MRD,     "lw_rd");
    add(0, LD, 0, 0, O_MWB,     "lw_wb");
    // sw with 2 stall cycles, then a stalled fetch
    add(0, ST, 0, 1, O_FETCH,   "sw_fetch");
    add(0, ST, 0, 1, O_DEC,     "sw_dec");
    add(0, ST, 0, 1, O_MADR,    "sw_madr");
    add(0, ST, 0, 0, O_MWR_S,   "sw_wr_s0");
    add(0, ST, 0, 0, O_MWR_S,   "sw_wr_s1");
    add(0, ST, 0, 1, O_MWR,     "sw_wr");
    add(0, BQ, 1, 0, O_FETCH_S, "fetch_stall");
    // beq taken then not taken
    add(0, BQ, 1, 1, O_FETCH,   "beq_t_fetch");
    add(0, BQ, 1, 1, O_DEC,     "beq_t_dec");
    add(0, BQ, 1, 1, O_BEQ_T,   "beq_taken");
    add(0, BQ, 0, 1, O_FETCH,   "beq_n_fetch");
    add(0, BQ, 0, 1, O_DEC,     "beq_n_dec");
    add(0, BQ, 0, 1, O_BEQ_N,   "beq_not_taken");
    // jal, jalr, lui, auipc, addi
    add(0, JL, 0, 1, O_FETCH,   "jal_fetch");
    add(0, JL, 0, 1, O_DEC,     "jal_dec");
    add(0, JL, 0, 1, O_JAL,     "jal_pc");
    add(0, JL, 0, 1, O_AWB,     "jal_wb");
    add(0, JR, 0, 1, O_FETCH,   "jalr_fetch");
    add(0, JR, 0, 1, O_DEC,     "jalr_dec");
    add(0, JR, 0, 1, O_JALR,    "jalr_tgt");
    add(0, JR, 0, 1, O_JPC,     "jalr_pc");
    add(0, JR, 0, 1, O_AWB,     "jalr_wb");
    add(0, LU, 0, 1, O_FETCH,   "lui_fetch");
    add(0, LU, 0, 1, O_DEC,     "lui_dec");
    add(0, LU, 0, 1, O_LUI,     "lui_exec");
    add(0, LU, 0, 1, O_AWB,     "lui_wb");
    add(0, AU, 0, 1, O_FETCH,   "auipc_fetch");
    add(0, AU, 0, 1, O_DEC,     "auipc_dec");
    add(0, AU, 0, 1, O_AWB,     "auipc_wb");
    add(0, RI, 0, 1, O_FETCH,   "addi_fetch");
    add(0, RI, 0, 1, O_DEC,     "addi_dec");
    add(0, RI, 0, 1, O_EXI,     "addi_exec");
    add(0, RI, 0, 1, O_AWB,     "addi_wb");
    // illegal opcode traps until reset
    add(0, BAD, 0, 1, O_FETCH,  "bad_fetch");
    add(0, BAD, 0, 1, O_DEC,    "bad_dec");
    for (int i = 0; i < 12; i++)
      add(0, (i % 3 == 0) ? RR : BAD, i[0], i[1], O_TRAP, "trap_hold");
    add(1, BAD, 0, 1, '0,       "trap_rst");
    add(0, ST, 0, 1, O_FETCH,   "post_trap_fetch");
    // reset during a MEMWRITE stall
    add(0, ST, 0, 1, O_DEC,     "swr_dec");
    add(0, ST, 0, 1, O_MADR,    "swr_madr");
    add(0, ST, 0, 0, O_MWR_S,   "swr_wr_s0");
    add(1, ST, 0, 0, '0,        "swr_rst");
    add(0, ST, 0, 0, O_FETCH_S, "swr_refetch");

    foreach (vt[i]) begin
      @(negedge clk);
      reset = vt[i].rst; op = vt[i].opc; zero = vt[i].z; mem_ready = vt[i].mr;
      #1 check(vt[i].name, vt[i].exp, vt[i].rst);
    end

    new_instr();
    for (int c = 0; c < 4000; c++) begin
      bit    rst;
      outs_t e;
      @(negedge clk);
      rst = (c == 0) || ($urandom_range(0, 59) == 0);
      reset = rst; op = cur_op;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      #1;
      if (rst) check("rand_reset", '0, 1);
      else begin
        e = seq[pos].o;
        if (seq[pos].wait_rdy && !mem_ready) begin
          e.pc_write = 1'b0; e.ir_write = 1'b0; e.instr_done = 1'b0;
        end
        if (seq[pos].br) e.pc_write = zero;
        check("rand_step", e, 0);
      end
      if (rst) new_instr();
      else if (!(seq[pos].sticky || (seq[pos].wait_rdy && !mem_ready))) begin
        pos++;
        if (pos == seq.size()) new_instr();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
